// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: region defaults,
// FSM state encoding, port identifiers and the region membership helper.
package mem_arbiter_pkg;

    // Default placement of the instruction and data regions.
    localparam logic [31:0] DEF_TEXT         = 32'h0040_0000;
    localparam logic [31:0] DEF_DATA         = 32'h1001_0000;
    localparam logic [31:0] DEF_REGION_BYTES = 32'd1024;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Requesting ports.
    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // True when addr lies in [base, base+size). The offset form avoids any
    // overflow of base+size near the top of the address space.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (off < size);
    endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Address legality check: word aligned and inside the TEXT or DATA region;
// instruction fetches are confined to the TEXT region.
module mem_addr_check
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] TEXT         = DEF_TEXT,
    parameter logic [31:0] DATA         = DEF_DATA,
    parameter logic [31:0] REGION_BYTES = DEF_REGION_BYTES
) (
    input  logic [31:0] addr_i,
    input  logic        is_fetch_i,
    output logic        legal_o
);

    logic aligned;
    logic in_text;
    logic in_data;

    // Combine alignment and region membership into the legal flag.
    always_comb begin
        aligned = (addr_i[1:0] == 2'b00);
        in_text = in_region(addr_i, TEXT, REGION_BYTES);
        in_data = in_region(addr_i, DATA, REGION_BYTES);
        legal_o = aligned && (in_text || (!is_fetch_i && in_data));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single shared memory.
// Each transaction is IDLE -> ACCESS (one memory cycle) -> RESP (one ack
// cycle); illegal requests skip ACCESS and are answered with err=1.
// Ties are resolved round-robin; all outputs come straight from registers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] TEXT         = DEF_TEXT,
    parameter logic [31:0] DATA         = DEF_DATA,
    parameter logic [31:0] REGION_BYTES = DEF_REGION_BYTES
) (
    input  logic        clock,
    input  logic        reset_n,
    // fetch port
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic        f_err,
    output logic [31:0] f_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // shared memory
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_e      state_q,       state_d;
    port_e       last_grant_q,  last_grant_d;
    port_e       grant_q,       grant_d;
    logic        f_ack_q,       f_ack_d;
    logic        f_err_q,       f_err_d;
    logic        d_ack_q,       d_ack_d;
    logic        d_err_q,       d_err_d;
    logic [31:0] f_rdata_q,     f_rdata_d;
    logic [31:0] d_rdata_q,     d_rdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q,   mem_wdata_d;
    logic        mem_read_q,    mem_read_d;
    logic        mem_write_q,   mem_write_d;

    logic        f_pend;
    logic        d_pend;
    logic        sel_valid;
    port_e       sel_port;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic        sel_legal;
    logic        sel_fetch;
    logic [31:0] capture;

    // Pick the candidate request; the port acked in RESP is masked that cycle.
    always_comb begin
        f_pend = f_req;
        d_pend = d_req;
        if (state_q == ST_RESP) begin
            if (grant_q == PORT_F) begin
                f_pend = 1'b0;
            end else begin
                d_pend = 1'b0;
            end
        end
        sel_valid = f_pend || d_pend;
        if (f_pend && d_pend) begin
            sel_port = (last_grant_q == PORT_D) ? PORT_F : PORT_D;
        end else if (f_pend) begin
            sel_port = PORT_F;
        end else begin
            sel_port = PORT_D;
        end
        sel_fetch = (sel_port == PORT_F);
        sel_addr  = sel_fetch ? f_addr : d_addr;
        sel_we    = !sel_fetch && d_we;
        sel_wdata = sel_fetch ? 32'd0 : d_wdata;
    end

    mem_addr_check #(
        .TEXT         (TEXT),
        .DATA         (DATA),
        .REGION_BYTES (REGION_BYTES)
    ) u_addr_check (
        .addr_i     (sel_addr),
        .is_fetch_i (sel_fetch),
        .legal_o    (sel_legal)
    );

    // Next-state and next-output logic; strobes and acks default to idle.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        f_ack_d       = 1'b0;
        f_err_d       = 1'b0;
        d_ack_d       = 1'b0;
        d_err_d       = 1'b0;
        f_rdata_d     = f_rdata_q;
        d_rdata_d     = d_rdata_q;
        mem_address_d = 32'd0;
        mem_wdata_d   = 32'd0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        capture       = mem_read_q ? mem_rdata : 32'd0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (sel_valid) begin
                    grant_d      = sel_port;
                    last_grant_d = sel_port;
                    if (sel_legal) begin
                        state_d       = ST_ACCESS;
                        mem_address_d = sel_addr;
                        mem_wdata_d   = sel_wdata;
                        mem_read_d    = !sel_we;
                        mem_write_d   = sel_we;
                    end else begin
                        // Illegal request: answer immediately, no memory cycle.
                        state_d = ST_RESP;
                        if (sel_fetch) begin
                            f_ack_d   = 1'b1;
                            f_err_d   = 1'b1;
                            f_rdata_d = 32'd0;
                        end else begin
                            d_ack_d   = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = 32'd0;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // Read data arrived on the falling edge; writes return 0.
                state_d = ST_RESP;
                if (grant_q == PORT_F) begin
                    f_ack_d   = 1'b1;
                    f_rdata_d = capture;
                end else begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = capture;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops strobes without waiting a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= PORT_D;
            grant_q       <= PORT_D;
            f_ack_q       <= 1'b0;
            f_err_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            d_err_q       <= 1'b0;
            f_rdata_q     <= 32'd0;
            d_rdata_q     <= 32'd0;
            mem_address_q <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            f_ack_q       <= f_ack_d;
            f_err_q       <= f_err_d;
            d_ack_q       <= d_ack_d;
            d_err_q       <= d_err_d;
            f_rdata_q     <= f_rdata_d;
            d_rdata_q     <= d_rdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

    assign f_ack       = f_ack_q;
    assign f_err       = f_err_q;
    assign f_rdata     = f_rdata_q;
    assign d_ack       = d_ack_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural shared memory.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'd0;
    logic        f_ack, f_err;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_address, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    logic [31:0] mem [logic [31:0]];

    mem_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_ack       (f_ack),
        .f_err       (f_err),
        .f_rdata     (f_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_err       (d_err),
        .d_rdata     (d_rdata),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory: writes commit on the rising edge, reads appear on the falling edge.
    always @(posedge clock) begin
        if (mem_write === 1'b1) mem[mem_address] = mem_wdata;
    end

    always @(negedge clock) begin
        if (mem_read === 1'b1) mem_rdata = mem.exists(mem_address) ? mem[mem_address] : 32'd0;
        else                   mem_rdata = 32'hDEAD_BEEF;
        if (mem_read === 1'b1 || mem_write === 1'b1) strobe_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one data request, wait for its ack, then settle back to IDLE.
    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int cycles);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        cycles = 0;
        do begin tick(); cycles++; end while (d_ack !== 1'b1 && cycles < 20);
        rdata = d_rdata; err = d_err;
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic f_txn(input logic [31:0] addr,
                         output logic [31:0] rdata, output logic err, output int cycles);
        f_req = 1'b1; f_addr = addr;
        cycles = 0;
        do begin tick(); cycles++; end while (f_ack !== 1'b1 && cycles < 20);
        rdata = f_rdata; err = f_err;
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({f_ack, f_err, d_ack, d_err, mem_read, mem_write} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000", {f_ack, f_err, d_ack, d_err, mem_read, mem_write});
        end
        checks++;
        if ({mem_address, mem_wdata, f_rdata, d_rdata} !== 128'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want zeros", mem_address, mem_wdata, f_rdata, d_rdata);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();
        checks++;
        if ({f_ack, d_ack, mem_read, mem_write} !== 4'b0) begin
            errors++; $display("FAIL post_reset_idle got %b want 0000", {f_ack, d_ack, mem_read, mem_write});
        end
    endtask

    task automatic test_tie();
        logic [31:0] rd; logic er; int cyc;
        f_req = 1'b1; f_addr = 32'h0040_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
        tick();
        checks++;
        if ({mem_read, mem_address} !== {1'b1, 32'h0040_0000}) begin
            errors++; $display("FAIL tie1_first_access got %b %h want 1 00400000", mem_read, mem_address);
        end
        tick();
        checks++;
        if ({f_ack, d_ack, f_err, f_rdata} !== {3'b100, 32'h0000_00A5}) begin
            errors++; $display("FAIL tie1_fetch_ack got %b%b%b %h want 100 000000a5", f_ack, d_ack, f_err, f_rdata);
        end
        f_req = 1'b0;
        tick();
        checks++;
        if ({mem_read, mem_address, f_ack} !== {1'b1, 32'h1001_0004, 1'b0}) begin
            errors++; $display("FAIL tie1_second_access got %b %h %b want 1 10010004 0", mem_read, mem_address, f_ack);
        end
        tick();
        checks++;
        if ({f_ack, d_ack, d_err, d_rdata} !== {3'b010, 32'd100}) begin
            errors++; $display("FAIL tie1_data_ack got %b%b%b %0d want 010 100", f_ack, d_ack, d_err, d_rdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if ({f_ack, d_ack, mem_read} !== 3'b000) begin
            errors++; $display("FAIL tie1_no_repeat got %b want 000", {f_ack, d_ack, mem_read});
        end
        // A lone fetch makes fetch the last grant, so the next tie goes to data.
        f_txn(32'h0040_0000, rd, er, cyc);
        checks++;
        if ({cyc, er, rd} !== {32'd2, 1'b0, 32'h0000_00A5}) begin
            errors++; $display("FAIL single_fetch got cyc=%0d err=%b rd=%h want 2 0 000000a5", cyc, er, rd);
        end
        f_req = 1'b1; f_addr = 32'h0040_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
        tick();
        checks++;
        if ({mem_read, mem_address} !== {1'b1, 32'h1001_0004}) begin
            errors++; $display("FAIL tie2_first_access got %b %h want 1 10010004", mem_read, mem_address);
        end
        tick();
        checks++;
        if ({f_ack, d_ack} !== 2'b01) begin
            errors++; $display("FAIL tie2_data_first got %b want 01", {f_ack, d_ack});
        end
        d_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({f_ack, d_ack, f_rdata} !== {2'b10, 32'h0000_00A5}) begin
            errors++; $display("FAIL tie2_fetch_second got %b %h want 10 000000a5", {f_ack, d_ack}, f_rdata);
        end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_data_read();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
        tick();
        checks++;
        if ({mem_read, mem_write, d_ack, mem_address} !== {3'b100, 32'h1001_0004}) begin
            errors++; $display("FAIL read_access got %b %h want 100 10010004", {mem_read, mem_write, d_ack}, mem_address);
        end
        tick();
        checks++;
        if ({mem_read, d_ack, d_err, d_rdata} !== {3'b010, 32'd100}) begin
            errors++; $display("FAIL read_ack got %b %0d want 010 100", {mem_read, d_ack, d_err}, d_rdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if ({d_ack, d_rdata} !== {1'b0, 32'd100}) begin
            errors++; $display("FAIL read_hold got %b %0d want 0 100", d_ack, d_rdata);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'd255;
        tick();
        checks++;
        if ({mem_write, mem_read, mem_wdata, mem_address} !== {2'b10, 32'd255, 32'h1001_0000}) begin
            errors++; $display("FAIL write_access got %b %0d %h want 10 255 10010000", {mem_write, mem_read}, mem_wdata, mem_address);
        end
        tick();
        checks++;
        if ({mem_write, d_ack, d_err, d_rdata} !== {3'b010, 32'd0}) begin
            errors++; $display("FAIL write_ack got %b %0d want 010 0", {mem_write, d_ack, d_err}, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        d_txn(1'b0, 32'h1001_0000, 32'd0, rd, er, cyc);
        checks++;
        if ({cyc, er, rd} !== {32'd2, 1'b0, 32'd255}) begin
            errors++; $display("FAIL write_readback got cyc=%0d err=%b rd=%0d want 2 0 255", cyc, er, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int cyc; int strobes_before;
        strobes_before = strobe_cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0002;
        tick();
        checks++;
        if ({d_ack, d_err, mem_read, mem_write, d_rdata} !== {4'b1100, 32'd0}) begin
            errors++; $display("FAIL d_misaligned got %b %h want 1100 0", {d_ack, d_err, mem_read, mem_write}, d_rdata);
        end
        d_req = 1'b0;
        tick();
        f_req = 1'b1; f_addr = 32'h1001_0000;
        tick();
        checks++;
        if ({f_ack, f_err, mem_read, mem_write, f_rdata} !== {4'b1100, 32'd0}) begin
            errors++; $display("FAIL f_data_region got %b %h want 1100 0", {f_ack, f_err, mem_read, mem_write}, f_rdata);
        end
        f_req = 1'b0;
        tick();
        checks++;
        if (strobe_cnt !== strobes_before) begin
            errors++; $display("FAIL err_no_strobe got %0d want %0d", strobe_cnt, strobes_before);
        end
        f_txn(32'h0040_0400, rd, er, cyc);
        checks++;
        if ({cyc, er} !== {32'd1, 1'b1}) begin
            errors++; $display("FAIL f_past_text got cyc=%0d err=%b want 1 1", cyc, er);
        end
        f_txn(32'h0040_03FC, rd, er, cyc);
        checks++;
        if ({cyc, er, rd} !== {32'd2, 1'b0, 32'h5555_AAAA}) begin
            errors++; $display("FAIL f_text_last got cyc=%0d err=%b rd=%h want 2 0 5555aaaa", cyc, er, rd);
        end
        d_txn(1'b0, 32'h1001_0400, 32'd0, rd, er, cyc);
        checks++;
        if ({cyc, er, rd} !== {32'd1, 1'b1, 32'd0}) begin
            errors++; $display("FAIL d_past_data got cyc=%0d err=%b rd=%h want 1 1 0", cyc, er, rd);
        end
        d_txn(1'b0, 32'h0040_03FC, 32'd0, rd, er, cyc);
        checks++;
        if ({cyc, er, rd} !== {32'd2, 1'b0, 32'h5555_AAAA}) begin
            errors++; $display("FAIL d_in_text got cyc=%0d err=%b rd=%h want 2 0 5555aaaa", cyc, er, rd);
        end
    endtask

    task automatic test_reset_during_write();
        logic [31:0] rd; logic er; int cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'd7;
        tick();
        checks++;
        if (mem_write !== 1'b1) begin
            errors++; $display("FAIL rst_write_start got %b want 1", mem_write);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, mem_read, d_ack, mem_address, d_rdata} !== {3'b000, 32'd0, 32'd0}) begin
            errors++; $display("FAIL rst_async got %b %h %h want 000 0 0", {mem_write, mem_read, d_ack}, mem_address, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        checks++;
        if ({d_ack, mem[32'h1001_0008]} !== {1'b0, 32'd50}) begin
            errors++; $display("FAIL rst_no_commit got ack=%b mem=%0d want 0 50", d_ack, mem[32'h1001_0008]);
        end
        @(negedge clock) reset_n = 1'b1;
        tick();
        d_txn(1'b0, 32'h1001_0008, 32'd0, rd, er, cyc);
        checks++;
        if ({cyc, er, rd} !== {32'd2, 1'b0, 32'd50}) begin
            errors++; $display("FAIL rst_readback got cyc=%0d err=%b rd=%0d want 2 0 50", cyc, er, rd);
        end
    endtask

    task automatic test_no_starve();
        int fcnt; int cyc;
        f_req = 1'b1; f_addr = 32'h0040_0000;
        for (int i = 0; i < 3; i++) begin
            repeat (i + 1) tick();
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
            fcnt = 0; cyc = 0;
            do begin
                tick(); cyc++;
                if (f_ack === 1'b1) fcnt++;
            end while (d_ack !== 1'b1 && cyc < 20);
            checks++;
            if (d_ack !== 1'b1 || fcnt > 1 || d_rdata !== 32'd100) begin
                errors++; $display("FAIL starve_%0d got ack=%b fetches=%0d rd=%0d want 1 <=1 100", i, d_ack, fcnt, d_rdata);
            end
            d_req = 1'b0;
        end
        f_req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        mem[32'h1001_0004] = 32'd100;
        mem[32'h0040_0000] = 32'h0000_00A5;
        mem[32'h0040_03FC] = 32'h5555_AAAA;
        mem[32'h1001_0008] = 32'd50;
        test_reset();
        test_tie();
        test_data_read();
        test_write_read();
        test_errors();
        test_reset_during_write();
        test_no_starve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TEXT, default 32'h00400000, byte base of instruction region.
REQ-002 Parameter DATA, default 32'h10010000, byte base of data region.
REQ-003 Parameter REGION_BYTES, default 1024, size of each region in bytes.
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 f_req / f_addr  in  1/32  fetch request, byte address; held stable until f_ack.
REQ-007 f_ack / f_err / f_rdata  out  1/1/32  fetch completion pulse, error flag, read word.
REQ-008 d_req / d_we / d_addr / d_wdata  in  1/1/32/32  data request, write enable, byte address, write word; held stable until d_ack.
REQ-009 d_ack / d_err / d_rdata  out  1/1/32  data completion pulse, error flag, read word.
REQ-010 mem_address / mem_wdata  out  32/32  byte address and write word to shared memory.
REQ-011 mem_read / mem_write  out  1/1  memory strobes; memory writes on rising edge, reads on falling edge.
REQ-012 mem_rdata  in  32  memory read word, valid from the falling edge of the read cycle.

Function
REQ-013 FSM states IDLE, ACCESS, RESP; all outputs SHALL be registered.
REQ-014 IDLE: if a legal request is pending, latch grant, address, we and wdata, and go to ACCESS; if the granted request is illegal, go directly to RESP with err=1.
REQ-015 Legal SHALL mean addr[1:0]==0 and addr in [TEXT, TEXT+REGION_BYTES) or [DATA, DATA+REGION_BYTES); fetch SHALL additionally require the TEXT region.
REQ-016 Arbitration: single requester wins; both pending -> the port not granted last wins (round-robin); last_grant resets to D so fetch wins the first tie.
REQ-017 ACCESS (exactly one cycle): mem_address=latched addr, mem_read=!we, mem_write=we, mem_wdata=latched wdata; other cycles mem_read=mem_write=0, mem_address=0, mem_wdata=0.
REQ-018 End of ACCESS: on a read, mem_rdata SHALL be captured into the granted port's rdata register; on a write, that rdata register SHALL be loaded with 0.
REQ-019 RESP (exactly one cycle): granted port's ack=1, err as decided; the other port's ack=0; rdata registers SHALL hold until next capture; an erroring port's rdata SHALL be 0.
REQ-020 Latency: request seen at edge k -> ACCESS cycle k+1 -> ack in cycle k+2; error responses: ack in cycle k+1.
REQ-021 RESP -> ACCESS/RESP directly if the other port has a pending request (back-to-back, 2-cycle throughput); otherwise RESP -> IDLE.
REQ-022 The just-acked port's req SHALL be ignored during its RESP cycle; it is re-sampled from the following cycle.
REQ-023 Requests arriving while not in IDLE/RESP SHALL wait; no request SHALL be dropped or serviced twice.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, all acks/errs/strobes 0, mem_address/mem_wdata 0, rdata registers 0, last_grant=D.
REQ-025 Reset asserted during ACCESS SHALL deassert mem_write before the next rising edge so no write commits; the interrupted request gets no ack.

Structure
REQ-026 Shared package SHALL hold TEXT, DATA, REGION_BYTES defaults and the FSM state encoding.
REQ-027 One combinational sub-module, mem_addr_check (addr, is_fetch -> legal), SHALL implement REQ-015.

Verification
REQ-028 d_req read d_addr=0x10010004, memory word 100 -> mem_read=1 one cycle, d_ack two cycles after request, d_rdata=100, d_err=0.
REQ-029 d_req write d_addr=0x10010000 d_wdata=255, then read same -> mem_write one cycle, second read returns 255.
REQ-030 f_req and d_req same cycle after reset -> fetch acked first, data acked 2 cycles later; repeat tie -> order alternates.
REQ-031 d_addr=0x10010002, then f_addr=0x10010000 -> each acked next cycle with err=1, rdata 0, no memory strobes.
REQ-032 reset_n low during write ACCESS to 0x10010008 (old 50, new 7) -> no ack, subsequent read returns 50.
REQ-033 f_req held continuously with d_req pulsing -> fetch never starves data beyond one transaction.
